// File: rtl/pipe_control.sv
// pipe_control: ID-stage main decoder, ID/EX control register and hazard FSM
// (load-use bubbles, branch/jump flush, external memory stall).
// Optional feature macro: IMM_OPS_EN (ADDI/ANDI/ORI/XORI/SLTI decode).
module pipe_control #(
  parameter int REG_AW          = 5,
  parameter int LU_STALL_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [5:0]        Opcode,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_br_taken,
  input  logic              mem_stall,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              ex_valid,
  output logic              ex_RegDst,
  output logic              ex_ALUSrc,
  output logic              ex_MemtoReg,
  output logic              ex_RegWrite,
  output logic              ex_MemRead,
  output logic              ex_MemWrite,
  output logic              ex_Branch,
  output logic              ex_Jump,
  output logic [1:0]        ex_ALUop,
  output logic [2:0]        ex_ImmOp,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic              illegal_op
);

  typedef enum logic {RUN, STALL} state_t;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic [1:0] alu_op;
    logic [2:0] imm_op;
  } ctrl_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef IMM_OPS_EN
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_SLTI = 6'b001010;
`endif

  localparam logic [2:0] STALL_INIT = 3'(LU_STALL_CYCLES - 1);

  state_t            state_q, state_d;
  logic [2:0]        stall_cnt_q, stall_cnt_d;
  logic              valid_q, valid_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [REG_AW-1:0] rs_q, rs_d;
  logic [REG_AW-1:0] rt_q, rt_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              ill_q, ill_d;

  ctrl_t             dec_ctrl;
  logic              dec_known;
  logic              lu;
  logic              do_bubble;
  logic              do_load;

  // Opcode decode into the EX control bundle; unknown opcodes give all-zero controls.
  always_comb begin
    dec_ctrl  = '0;
    dec_known = 1'b1;
    case (Opcode)
      OP_R: begin
        dec_ctrl.reg_dst   = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_op    = 2'b10;
      end
      OP_LW: begin
        dec_ctrl.alu_src    = 1'b1;
        dec_ctrl.mem_to_reg = 1'b1;
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.mem_read   = 1'b1;
      end
      OP_SW: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.mem_write = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        dec_ctrl.branch = 1'b1;
        dec_ctrl.alu_op = 2'b01;
      end
      OP_J: begin
        dec_ctrl.jump = 1'b1;
      end
`ifdef IMM_OPS_EN
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_op    = 2'b11;
        case (Opcode)
          OP_ANDI: dec_ctrl.imm_op = 3'b001;
          OP_ORI:  dec_ctrl.imm_op = 3'b010;
          OP_XORI: dec_ctrl.imm_op = 3'b011;
          OP_SLTI: dec_ctrl.imm_op = 3'b100;
          default: dec_ctrl.imm_op = 3'b000;
        endcase
      end
`endif
      default: dec_known = 1'b0;
    endcase
  end

  // Load-use hazard: the load now in EX writes a register the ID instruction reads.
  always_comb begin
    lu = valid_q & ctrl_q.mem_read & (rt_q != '0) &
         ((rt_q == id_rs) | (rt_q == id_rt)) & id_valid;
  end

  // Hazard priority and next-state: mem_stall > branch flush > load-use/STALL > jump > normal.
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    valid_d     = valid_q;
    ctrl_d      = ctrl_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    rd_d        = rd_q;
    ill_d       = 1'b0;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    do_bubble   = 1'b0;
    do_load     = 1'b0;

    if (mem_stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (ex_br_taken) begin
      ifid_flush  = 1'b1;
      do_bubble   = 1'b1;
      state_d     = RUN;
      stall_cnt_d = '0;
    end else if (state_q == STALL) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      do_bubble   = 1'b1;
      stall_cnt_d = stall_cnt_q - 3'd1;
      if (stall_cnt_q == 3'd1) state_d = RUN;
    end else if (lu) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      do_bubble  = 1'b1;
      if (LU_STALL_CYCLES > 1) begin
        state_d     = STALL;
        stall_cnt_d = STALL_INIT;
      end
    end else begin
      do_load = 1'b1;
      if (id_valid && dec_ctrl.jump) ifid_flush = 1'b1;
    end

    // An invalid ID slot loads as a bubble too.
    if (do_bubble || (do_load && !id_valid)) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      rs_d    = '0;
      rt_d    = '0;
      rd_d    = '0;
    end else if (do_load) begin
      valid_d = 1'b1;
      ctrl_d  = dec_ctrl;
      rs_d    = id_rs;
      rt_d    = id_rt;
      rd_d    = id_rd;
      ill_d   = ~dec_known;
    end
  end

  // FSM state, stall counter and ID/EX bundle registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      valid_q     <= 1'b0;
      ctrl_q      <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      ill_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      valid_q     <= valid_d;
      ctrl_q      <= ctrl_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      ill_q       <= ill_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_RegDst   = ctrl_q.reg_dst;
  assign ex_ALUSrc   = ctrl_q.alu_src;
  assign ex_MemtoReg = ctrl_q.mem_to_reg;
  assign ex_RegWrite = ctrl_q.reg_write;
  assign ex_MemRead  = ctrl_q.mem_read;
  assign ex_MemWrite = ctrl_q.mem_write;
  assign ex_Branch   = ctrl_q.branch;
  assign ex_Jump     = ctrl_q.jump;
  assign ex_ALUop    = ctrl_q.alu_op;
  assign ex_ImmOp    = ctrl_q.imm_op;
  assign ex_rs       = rs_q;
  assign ex_rt       = rt_q;
  assign ex_rd       = rd_q;
  assign illegal_op  = ill_q;

endmodule

// File: tb/tb_pipe_control.sv
// Bench for pipe_control: two instances (LU_STALL_CYCLES 1 and 3) share stimulus and
// are each compared against a bubbles-owed reference model.
module tb_pipe_control;

  localparam int AW = 5;
  localparam int BW = 1 + 13 + 3*AW + 1;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, id_valid, ex_br_taken, mem_stall;
  logic [5:0]    Opcode;
  logic [AW-1:0] id_rs, id_rt, id_rd;

  logic [1:0] pc_w, ifid_w, ifid_f, ex_v, rdst, alusrc, m2r, regw, memr, memw, brn, jmp, ill;
  logic [1:0][1:0]    aluop;
  logic [1:0][2:0]    immop;
  logic [1:0][AW-1:0] ers, ert, erd;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    pipe_control #(.REG_AW(AW), .LU_STALL_CYCLES((g == 0) ? 1 : 3)) u_dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .Opcode(Opcode),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .ex_br_taken(ex_br_taken), .mem_stall(mem_stall),
      .pc_write(pc_w[g]), .ifid_write(ifid_w[g]), .ifid_flush(ifid_f[g]),
      .ex_valid(ex_v[g]), .ex_RegDst(rdst[g]), .ex_ALUSrc(alusrc[g]),
      .ex_MemtoReg(m2r[g]), .ex_RegWrite(regw[g]), .ex_MemRead(memr[g]),
      .ex_MemWrite(memw[g]), .ex_Branch(brn[g]), .ex_Jump(jmp[g]),
      .ex_ALUop(aluop[g]), .ex_ImmOp(immop[g]),
      .ex_rs(ers[g]), .ex_rt(ert[g]), .ex_rd(erd[g]), .illegal_op(ill[g])
    );
  end

  int checks = 0;
  int errors = 0;

  // Reference model: EX contents plus the number of bubbles still owed.
  logic          m_valid [2];
  logic [12:0]   m_ctrl  [2];
  logic [AW-1:0] m_rs [2], m_rt [2], m_rd [2];
  logic          m_ill   [2];
  int            m_left  [2];
  logic [2:0]    exp_comb [2];
  logic [2:0]    obs_comb [2];

  function automatic int lu_of(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // {known, RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,Jump,ALUop[1:0],ImmOp[2:0]}
  function automatic logic [13:0] spec_decode(logic [5:0] op);
    case (op)
      OP_R:          return 14'b1_1001_0000_10_000;
      OP_LW:         return 14'b1_0111_1000_00_000;
      OP_SW:         return 14'b1_0100_0100_00_000;
      OP_BEQ, OP_BNE:return 14'b1_0000_0010_01_000;
      OP_J:          return 14'b1_0000_0001_00_000;
`ifdef IMM_OPS_EN
      OP_ADDI:       return 14'b1_0101_0000_11_000;
      OP_ANDI:       return 14'b1_0101_0000_11_001;
      OP_ORI:        return 14'b1_0101_0000_11_010;
      OP_XORI:       return 14'b1_0101_0000_11_011;
      OP_SLTI:       return 14'b1_0101_0000_11_100;
`endif
      default:       return 14'b0;
    endcase
  endfunction

  function automatic logic model_hazard(int i);
    return m_valid[i] && m_ctrl[i][8] && (m_rt[i] != '0) &&
           ((m_rt[i] == id_rs) || (m_rt[i] == id_rt)) && id_valid;
  endfunction

  function automatic logic [BW-1:0] model_bus(int i);
    return {m_valid[i], m_ctrl[i], m_rs[i], m_rt[i], m_rd[i], m_ill[i]};
  endfunction

  function automatic logic [BW-1:0] dut_bus(int i);
    return {ex_v[i], rdst[i], alusrc[i], m2r[i], regw[i], memr[i], memw[i], brn[i], jmp[i],
            aluop[i], immop[i], ers[i], ert[i], erd[i], ill[i]};
  endfunction

  task automatic model_bubble(int i);
    m_valid[i] = 1'b0; m_ctrl[i] = '0; m_rs[i] = '0; m_rt[i] = '0; m_rd[i] = '0; m_ill[i] = 1'b0;
  endtask

  // One clock: predict/sample comb outputs before the edge, advance the model at the edge,
  // return on the following falling edge with registered outputs settled.
  task automatic step();
    for (int i = 0; i < 2; i++) begin
      if (mem_stall)                            exp_comb[i] = 3'b000;
      else if (ex_br_taken)                     exp_comb[i] = 3'b111;
      else if (m_left[i] > 0 || model_hazard(i)) exp_comb[i] = 3'b000;
      else exp_comb[i] = {2'b11, id_valid && (Opcode == OP_J)};
    end
    #1;
    for (int i = 0; i < 2; i++) obs_comb[i] = {pc_w[i], ifid_w[i], ifid_f[i]};
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      logic        haz;
      logic [13:0] d;
      haz = model_hazard(i);
      d   = spec_decode(Opcode);
      if (!rst) begin
        model_bubble(i); m_left[i] = 0;
      end else if (mem_stall) begin
        m_ill[i] = 1'b0;
      end else if (ex_br_taken) begin
        model_bubble(i); m_left[i] = 0;
      end else if (m_left[i] > 0) begin
        model_bubble(i); m_left[i] = m_left[i] - 1;
      end else if (haz) begin
        model_bubble(i); m_left[i] = lu_of(i) - 1;
      end else if (!id_valid) begin
        model_bubble(i);
      end else begin
        m_valid[i] = 1'b1; m_ctrl[i] = d[12:0];
        m_rs[i] = id_rs; m_rt[i] = id_rt; m_rd[i] = id_rd; m_ill[i] = ~d[13];
      end
    end
    @(negedge clk);
  endtask

  task automatic set_id(logic v, logic [5:0] op, logic [AW-1:0] rs, logic [AW-1:0] rt,
                        logic [AW-1:0] rd);
    id_valid = v; Opcode = op; id_rs = rs; id_rt = rt; id_rd = rd;
  endtask

  task automatic do_reset();
    rst = 1'b0; mem_stall = 1'b0; ex_br_taken = 1'b0;
    set_id(1'b0, OP_R, '0, '0, '0);
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; mem_stall = 1'b0; ex_br_taken = 1'b0;
    set_id(1'b1, OP_LW, 5'd1, 5'd2, 5'd3);
    step();
    step();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dut_bus(i) !== '0) begin
        errors++; $display("FAIL reset_bus inst%0d: got %h expected 0", i, dut_bus(i));
      end
    end
    rst = 1'b1;
    set_id(1'b1, OP_R, 5'd1, 5'd2, 5'd3);
    step();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs_comb[i] !== 3'b110) begin
        errors++; $display("FAIL reset_release_comb inst%0d: got %b expected 110", i, obs_comb[i]);
      end
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1'b1, OP_LW, 5'd1, 5'd5, 5'd0);
    step();
    set_id(1'b1, OP_R, 5'd5, 5'd2, 5'd7);
    step();
    checks++;
    if (obs_comb[0] !== 3'b000) begin
      errors++; $display("FAIL lu_stall_comb: got %b expected 000", obs_comb[0]);
    end
    checks++;
    if (ex_v[0] !== 1'b0) begin
      errors++; $display("FAIL lu_bubble: ex_valid got %b expected 0", ex_v[0]);
    end
    step();
    checks++;
    if (obs_comb[0] !== 3'b110) begin
      errors++; $display("FAIL lu_resume_comb: got %b expected 110", obs_comb[0]);
    end
    checks++;
    if ({ex_v[0], rdst[0], ers[0], erd[0]} !== {1'b1, 1'b1, 5'd5, 5'd7}) begin
      errors++; $display("FAIL lu_add_in_ex: got v%b rd%b rs%0d rd%0d expected v1 rd1 rs5 rd7",
                         ex_v[0], rdst[0], ers[0], erd[0]);
    end
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (dut_bus(i) !== model_bus(i)) begin
          errors++; $display("FAIL lu_model inst%0d: got %h expected %h", i, dut_bus(i), model_bus(i));
        end
      end
      step();
    end
  endtask

  task automatic test_branch_abort();
    do_reset();
    set_id(1'b1, OP_LW, 5'd1, 5'd5, 5'd0);
    step();
    set_id(1'b1, OP_R, 5'd5, 5'd2, 5'd7);
    step();
    ex_br_taken = 1'b1;
    step();
    checks++;
    if (obs_comb[1] !== 3'b111) begin
      errors++; $display("FAIL br_flush_comb: got %b expected 111", obs_comb[1]);
    end
    checks++;
    if (ex_v[1] !== 1'b0) begin
      errors++; $display("FAIL br_bubble: ex_valid got %b expected 0", ex_v[1]);
    end
    ex_br_taken = 1'b0;
    set_id(1'b0, OP_R, 5'd5, 5'd2, 5'd7);
    step();
    checks++;
    if (obs_comb[1] !== 3'b110) begin
      errors++; $display("FAIL br_back_to_run: got %b expected 110", obs_comb[1]);
    end
    set_id(1'b1, OP_SW, 5'd1, 5'd2, 5'd0);
    step();
    checks++;
    if ({ex_v[1], rdst[1], memw[1]} !== 3'b101) begin
      errors++; $display("FAIL br_add_dropped: got v%b regdst%b memw%b expected v1 regdst0 memw1",
                         ex_v[1], rdst[1], memw[1]);
    end
  endtask

  task automatic test_mem_stall();
    int got;
    do_reset();
    set_id(1'b1, OP_LW, 5'd1, 5'd5, 5'd0);
    step();
    set_id(1'b1, OP_R, 5'd5, 5'd2, 5'd7);
    step();
    mem_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_comb[i] !== 3'b000 || dut_bus(i) !== '0) begin
          errors++; $display("FAIL ms_freeze inst%0d: comb %b bus %h expected 000 / 0",
                             i, obs_comb[i], dut_bus(i));
        end
      end
    end
    mem_stall = 1'b0;
    step();
    checks++;
    if ({rdst[0], ex_v[1]} !== 2'b10) begin
      errors++; $display("FAIL ms_resume: got lu1_regdst%b lu3_valid%b expected 1 0",
                         rdst[0], ex_v[1]);
    end
    got = 0;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (rdst[1] === 1'b1) begin got = n; break; end
    end
    checks++;
    if (got != 2) begin
      errors++; $display("FAIL ms_remaining_bubbles: ADD after %0d cycles expected 2 (0=timeout)", got);
    end
  endtask

  task automatic test_jump_branch();
    do_reset();
    set_id(1'b1, OP_J, 5'd0, 5'd0, 5'd0);
    step();
    checks++;
    if (obs_comb[0] !== 3'b111) begin
      errors++; $display("FAIL jump_flush_comb: got %b expected 111", obs_comb[0]);
    end
    checks++;
    if (jmp[0] !== 1'b1) begin
      errors++; $display("FAIL jump_ex: ex_Jump got %b expected 1", jmp[0]);
    end
    set_id(1'b1, OP_BEQ, 5'd3, 5'd4, 5'd0);
    step();
    checks++;
    if ({aluop[0], brn[0], jmp[0]} !== 4'b0110) begin
      errors++; $display("FAIL beq_ex: got aluop%b br%b j%b expected 01 1 0", aluop[0], brn[0], jmp[0]);
    end
  endtask

  task automatic test_imm();
    do_reset();
    set_id(1'b1, OP_ORI, 5'd1, 5'd2, 5'd3);
    step();
`ifdef IMM_OPS_EN
    checks++;
    if ({aluop[0], immop[0], memr[0], alusrc[0], ill[0]} !== 8'b11_010_0_1_0) begin
      errors++; $display("FAIL ori_decode: got aluop%b imm%b mr%b as%b ill%b expected 11 010 0 1 0",
                         aluop[0], immop[0], memr[0], alusrc[0], ill[0]);
    end
`else
    checks++;
    if ({ill[0], aluop[0], immop[0]} !== 6'b1_00_000) begin
      errors++; $display("FAIL ori_illegal: got ill%b aluop%b imm%b expected 1 00 000",
                         ill[0], aluop[0], immop[0]);
    end
`endif
    set_id(1'b1, OP_R, 5'd1, 5'd2, 5'd3);
    step();
    checks++;
    if (ill[0] !== 1'b0) begin
      errors++; $display("FAIL illegal_pulse: illegal_op got %b expected 0", ill[0]);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [12];
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI,
            OP_SLTI, 6'b111111};
    do_reset();
    for (int c = 0; c < 500; c++) begin
      int sel;
      rst         = ($urandom_range(0, 49) != 0);
      mem_stall   = ($urandom_range(0, 7) == 0);
      ex_br_taken = ($urandom_range(0, 9) == 0);
      sel = $urandom_range(0, 12);
      set_id($urandom_range(0, 7) != 0, (sel == 12) ? 6'($urandom) : ops[sel],
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
      step();
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          checks++;
          if (obs_comb[i] !== exp_comb[i]) begin
            errors++; $display("FAIL rand_comb inst%0d cyc%0d: got %b expected %b",
                               i, c, obs_comb[i], exp_comb[i]);
          end
        end
        checks++;
        if (dut_bus(i) !== model_bus(i)) begin
          errors++; $display("FAIL rand_bus inst%0d cyc%0d: got %h expected %h",
                             i, c, dut_bus(i), model_bus(i));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0; id_valid = 1'b0; Opcode = '0; id_rs = '0; id_rt = '0; id_rd = '0;
    ex_br_taken = 1'b0; mem_stall = 1'b0;
    for (int i = 0; i < 2; i++) begin
      model_bubble(i); m_left[i] = 0;
    end
    @(negedge clk);
    test_reset();
    test_load_use();
    test_branch_abort();
    test_mem_stall();
    test_jump_branch();
    test_imm();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
